// File: rtl/cfa_pkg.sv
// Shared defaults and helpers for the CFA green abs-diff pipeline.
// Build option: define CFA_ABSDIFF_SAT_EN to clamp over-range |h-v| to the
// output maximum; left undefined, only the low output bits are kept (wrap).
package cfa_pkg;
  localparam int PIXEL_W_DEF = 14;
  localparam int LANES_DEF   = 2;
  localparam int ACC_W_DEF   = 24;

  // Widest signed difference abs_reduce() accepts (MAX_W+1 bits incl. sign).
  localparam int MAX_W = 32;

  // LSB position of a lane within a flat lane-0-in-LSBs bus.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Magnitude of a sign-extended difference, reduced to ow bits.
  // Upper bits of the result are always zero; callers size-cast to ow.
  function automatic logic [MAX_W:0] abs_reduce(input logic [MAX_W:0] diff, input int ow);
    logic [MAX_W:0] mag;
    logic [MAX_W:0] lim;
    mag = diff[MAX_W] ? (~diff + {{MAX_W{1'b0}}, 1'b1}) : diff;
    lim = ({{MAX_W{1'b0}}, 1'b1} << ow) - {{MAX_W{1'b0}}, 1'b1};
`ifdef CFA_ABSDIFF_SAT_EN
    if (mag > lim) mag = lim;
`else
    mag = mag;
`endif
    return mag & lim;
  endfunction
endpackage

// File: rtl/cfa_abs_lane.sv
// One lane of the abs-diff datapath: stage-1 difference register and
// stage-2 magnitude/direction registers. Valid/last and stall control
// live in the top; this block only loads when told to.
// Build option: CFA_ABSDIFF_SAT_EN (see cfa_pkg) selects clamp vs wrap.
module cfa_abs_lane
  import cfa_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en1_i,
  input  logic               en2_i,
  input  logic [PIXEL_W-1:0] h_i,
  input  logic [PIXEL_W-1:0] v_i,
  output logic [PIXEL_W-2:0] absdiff_o,
  output logic               h_ge_v_o
);
  localparam int AW = PIXEL_W - 1;

  logic [PIXEL_W:0] diff_q, diff_d;
  logic [AW-1:0]    abs_q, abs_d;
  logic             ge_q, ge_d;

  // Next-state: zero-extended subtract; magnitude and sign from stage 1.
  always_comb begin
    diff_d = {1'b0, h_i} - {1'b0, v_i};
    abs_d  = AW'(abs_reduce({{(MAX_W-PIXEL_W){diff_q[PIXEL_W]}}, diff_q}, AW));
    ge_d   = ~diff_q[PIXEL_W];
  end

  // Stage registers load only on their stage enable so stalls hold data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      abs_q  <= '0;
      ge_q   <= 1'b0;
    end else begin
      if (en1_i) diff_q <= diff_d;
      if (en2_i) begin
        abs_q <= abs_d;
        ge_q  <= ge_d;
      end
    end
  end

  assign absdiff_o = abs_q;
  assign h_ge_v_o  = ge_q;
endmodule

// File: rtl/cfa_abs_diff_pipe.sv
// Multi-lane streaming |green_h - green_v| with a 2-stage valid/ready
// pipeline (bubbles collapse, no skid) and a saturating per-line sum.
// Build option: CFA_ABSDIFF_SAT_EN clamps over-range lane results.
module cfa_abs_diff_pipe
  import cfa_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic [LANES*PIXEL_W-1:0]   green_h,
  input  logic [LANES*PIXEL_W-1:0]   green_v,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [LANES*(PIXEL_W-1)-1:0] m_absdiff,
  output logic [LANES-1:0]           m_h_ge_v,
  output logic [ACC_W-1:0]           line_sum,
  output logic                       line_sum_valid
);
  localparam int AW    = PIXEL_W - 1;
  localparam int SUM_W = AW + $clog2(LANES) + 1;
  localparam int TW    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  logic v1_q, v2_q, last1_q, last2_q;
  logic en1, en2, fire;

  logic [LANES-1:0][AW-1:0] absd;
  logic [LANES-1:0]         ge;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] line_sum_q;
  logic             lsv_q;
  logic [SUM_W-1:0] beat_sum;
  logic [TW-1:0]    acc_tot;

  // Stage 2 advances when empty or drained; stage 1 when it can push on.
  assign en2     = !v2_q || m_ready;
  assign en1     = !v1_q || en2;
  assign s_ready = en1;
  assign fire    = v2_q && m_ready;

  // Valid/last pipeline follows the same enables as the lane data regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      if (en1) begin
        v1_q    <= s_valid;
        last1_q <= s_last;
      end
      if (en2) begin
        v2_q    <= v1_q;
        last2_q <= last1_q;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    cfa_abs_lane #(.PIXEL_W(PIXEL_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en1_i     (en1),
      .en2_i     (en2),
      .h_i       (green_h[lane_lo(l, PIXEL_W) +: PIXEL_W]),
      .v_i       (green_v[lane_lo(l, PIXEL_W) +: PIXEL_W]),
      .absdiff_o (absd[l]),
      .h_ge_v_o  (ge[l])
    );
  end

  assign m_valid   = v2_q;
  assign m_last    = last2_q;
  assign m_absdiff = absd;
  assign m_h_ge_v  = ge;

  // Lane sum of the output beat and saturating running total.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) beat_sum = beat_sum + SUM_W'(absd[l]);
    acc_tot = TW'(acc_q) + TW'(beat_sum);
    acc_d   = (acc_tot > TW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : acc_tot[ACC_W-1:0];
  end

  // Accumulate on each delivered beat; publish and clear on end of line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      line_sum_q <= '0;
      lsv_q      <= 1'b0;
    end else begin
      lsv_q <= 1'b0;
      if (fire) begin
        if (last2_q) begin
          line_sum_q <= acc_d;
          lsv_q      <= 1'b1;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

  assign line_sum       = line_sum_q;
  assign line_sum_valid = lsv_q;
endmodule

// File: tb/tb_cfa_abs_diff_pipe.sv
// Scoreboard bench for cfa_abs_diff_pipe: a default-width instance and an
// ACC_W=8 instance share all inputs; expectations come from a lane model.
module tb_cfa_abs_diff_pipe;
  localparam int PW = 14;
  localparam int LN = 2;
  localparam int AW = PW - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [LN*PW-1:0] green_h = '0, green_v = '0;

  logic s_ready, m_valid, m_last, line_sum_valid;
  logic [LN*AW-1:0] m_absdiff;
  logic [LN-1:0]    m_h_ge_v;
  logic [23:0]      line_sum;

  logic s_ready8, m_valid8, m_last8, line_sum_valid8;
  logic [LN*AW-1:0] m_absdiff8;
  logic [LN-1:0]    m_h_ge_v8;
  logic [7:0]       line_sum8;

  cfa_abs_diff_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .green_h(green_h), .green_v(green_v), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_absdiff(m_absdiff), .m_h_ge_v(m_h_ge_v),
    .line_sum(line_sum), .line_sum_valid(line_sum_valid)
  );

  cfa_abs_diff_pipe #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8), .s_last(s_last),
    .green_h(green_h), .green_v(green_v), .m_valid(m_valid8), .m_ready(m_ready),
    .m_last(m_last8), .m_absdiff(m_absdiff8), .m_h_ge_v(m_h_ge_v8),
    .line_sum(line_sum8), .line_sum_valid(line_sum_valid8)
  );

  always #5 clk = ~clk;

  typedef struct { logic [LN*PW-1:0] h, v; logic last; } beat_t;
  typedef struct { logic [LN*AW-1:0] ad; logic [LN-1:0] ge; logic last; int t; } exp_t;

  beat_t in_q[$];
  exp_t  exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  bit mr_toggle = 0, lat_chk = 0, pend = 0, stall = 0;
  longint acc24 = 0, acc8 = 0, ls24 = 0, ls8 = 0;
  logic [LN*AW-1:0] pv_ad;
  logic [LN-1:0]    pv_ge;
  logic             pv_last;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] mdl_abs(input int h, input int v);
    int d;
    d = h - v;
    if (d < 0) d = -d;
`ifdef CFA_ABSDIFF_SAT_EN
    if (d > (1 << AW) - 1) d = (1 << AW) - 1;
`endif
    return AW'(d);
  endfunction

  task automatic push_beat(input int h0, input int v0, input int h1, input int v1, input bit last);
    beat_t b;
    b.h = {PW'(h1), PW'(h0)};
    b.v = {PW'(v1), PW'(v0)};
    b.last = last;
    in_q.push_back(b);
  endtask

  // One clock cycle: drive at negedge, check settled outputs, update model.
  task automatic step();
    beat_t b;
    exp_t  e, o;
    longint sum;
    @(negedge clk);
    cyc++;
    m_ready = mr_toggle ? ((cyc % 2) == 0) : 1'b1;
    if (in_q.size() != 0) begin
      b = in_q[0];
      s_valid = 1'b1; green_h = b.h; green_v = b.v; s_last = b.last;
    end else begin
      s_valid = 1'b0; s_last = 1'b0;
    end
    #1;
    chk("line_sum_valid", line_sum_valid, pend);
    chk("line_sum_valid8", line_sum_valid8, pend);
    pend = 0;
    chk("line_sum", line_sum, ls24);
    chk("line_sum8", line_sum8, ls8);
    chk("s_ready", s_ready, !(exp_q.size() == 2 && !m_ready));
    if (stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_absdiff", m_absdiff, pv_ad);
      chk("stall_ge", m_h_ge_v, pv_ge);
      chk("stall_last", m_last, pv_last);
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("spurious_beat", m_valid, 0);
      else begin
        o = exp_q.pop_front();
        chk("absdiff", m_absdiff, o.ad);
        chk("h_ge_v", m_h_ge_v, o.ge);
        chk("m_last", m_last, o.last);
        if (lat_chk) chk("latency", cyc - o.t, 2);
        sum = 0;
        for (int l = 0; l < LN; l++) sum += o.ad[l*AW +: AW];
        acc24 = (acc24 + sum > 64'hFFFFFF) ? 64'hFFFFFF : acc24 + sum;
        acc8  = (acc8 + sum > 255) ? 255 : acc8 + sum;
        if (o.last) begin
          ls24 = acc24; ls8 = acc8; acc24 = 0; acc8 = 0; pend = 1;
        end
      end
    end
    stall = m_valid && !m_ready;
    pv_ad = m_absdiff; pv_ge = m_h_ge_v; pv_last = m_last;
    if (s_valid && s_ready) begin
      for (int l = 0; l < LN; l++) begin
        e.ad[l*AW +: AW] = mdl_abs(int'(b.h[l*PW +: PW]), int'(b.v[l*PW +: PW]));
        e.ge[l] = (b.h[l*PW +: PW] >= b.v[l*PW +: PW]);
      end
      e.last = b.last;
      e.t = cyc;
      exp_q.push_back(e);
      void'(in_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", in_q.size() + exp_q.size(), 0);
    mr_toggle = 0;
    step();
    step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_valid8", m_valid8, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_absdiff", m_absdiff, 0);
    chk("rst_ge", m_h_ge_v, 0);
    chk("rst_line_sum", line_sum, 0);
    chk("rst_line_sum8", line_sum8, 0);
    chk("rst_lsv", line_sum_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    in_q.delete(); exp_q.delete();
    acc24 = 0; acc8 = 0; ls24 = 0; ls8 = 0; pend = 0; stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state
    do_reset();

    // 2: basic lanes and 2-cycle latency
    lat_chk = 1;
    push_beat(100, 40, 40, 100, 1);
    drain(20);
    lat_chk = 0;

    // 3: over-range lane (clamp or wrap) and equal inputs
    push_beat(12000, 0, 0, 0, 0);
    push_beat(5000, 5000, 0, 0, 1);
    drain(20);

    // 4: 10 back-to-back beats with m_ready toggling
    mr_toggle = 1;
    for (int i = 0; i < 10; i++)
      push_beat($urandom_range(0, 16383), $urandom_range(0, 16383),
                $urandom_range(0, 16383), $urandom_range(0, 16383), i == 9);
    drain(200);

    // 5: 3-beat line summing 60, then 1-beat line summing 5
    push_beat(10, 0, 0, 0, 0);
    push_beat(5, 0, 0, 15, 0);
    push_beat(30, 0, 0, 0, 1);
    drain(20);
    chk("t5_line_sum", line_sum, 60);
    push_beat(0, 5, 0, 0, 1);
    drain(20);
    chk("t5_single_beat", line_sum, 5);

    // 6: saturation in the narrow accumulator, then reset mid-line
    push_beat(100, 0, 0, 100, 0);
    push_beat(0, 50, 50, 0, 0);
    push_beat(0, 0, 0, 0, 1);
    drain(20);
    chk("t6_sat8", line_sum8, 255);
    chk("t6_wide", line_sum, 300);
    push_beat(1000, 0, 0, 0, 0);
    drain(20);
    push_beat(2000, 0, 0, 0, 0);
    step();
    do_reset();
    push_beat(7, 0, 0, 3, 1);
    drain(20);
    chk("t6_after_rst", line_sum, 10);
    chk("t6_after_rst8", line_sum8, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
